// File: rtl/reg8_readout_pkg.sv
// Shared types and default sizes for the register-file readout sequencer.
package reg8_readout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SEL_W = 3;

endpackage

// File: rtl/reg8_settle_cnt.sv
// Dwell down-counter: load reloads MAX-1, done flags a zero count.
module reg8_settle_cnt #(
  parameter int unsigned MAX = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(MAX - 1);
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/reg8_readout.sv
// Walks rsel over the register file, packs the returned bits into one word
// and offers it on a valid/ready port.
module reg8_readout
  import reg8_readout_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SEL_W         = $clog2(WIDTH),
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             q_in,
  output logic [SEL_W-1:0] rsel,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  state_e           state_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] rsel_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] dout_q;
  logic             busy_q;
  logic             valid_q;
  logic             cnt_done;
  logic             cnt_load;
  logic             last;

  assign last     = (idx_q == SEL_W'(WIDTH - 1));
  assign cnt_load = (state_q == IDLE && start) ||
                    (state_q == SCAN && cnt_done);

  reg8_settle_cnt #(
    .MAX(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .clr   (clr),
    .load_i(cnt_load),
    .en_i  (state_q == SCAN),
    .done_o(cnt_done)
  );

  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[idx_q] = q_in;
  end

  // dout only moves when the full word lands, so it never shows a partial scan
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rsel_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (cnt_done) begin
            shadow_q <= shadow_d;
            if (last) begin
              state_q <= HOLD;
              dout_q  <= shadow_d;
              valid_q <= 1'b1;
              idx_q   <= '0;
              rsel_q  <= '0;
            end else begin
              idx_q  <= idx_q + SEL_W'(1);
              rsel_q <= idx_q + SEL_W'(1);
            end
          end
        end
        HOLD: begin
          if (dout_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rsel_q  <= '0;
          if (start) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign rsel       = rsel_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_reg8_readout.sv
// Directed bench for reg8_readout with a modelled register file.
module tb_reg8_readout;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] mem1, mem3;

  logic       start1, ready1, valid1, busy1, q1;
  logic [2:0] rsel1;
  logic [7:0] dout1;

  logic       start3, ready3, valid3, busy3, q3;
  logic [2:0] rsel3;
  logic [7:0] dout3;

  int passes = 0;
  int checks = 0;
  int words1 = 0;

  always #5 clk = ~clk;

  assign q1 = mem1[rsel1];
  assign q3 = mem3[rsel3];

  reg8_readout #(.WIDTH(8), .SEL_W(3), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .q_in(q1), .rsel(rsel1),
    .busy(busy1), .dout(dout1), .dout_valid(valid1), .dout_ready(ready1)
  );

  reg8_readout #(.WIDTH(8), .SEL_W(3), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .clr(clr), .start(start3), .q_in(q3), .rsel(rsel3),
    .busy(busy3), .dout(dout3), .dout_valid(valid3), .dout_ready(ready3)
  );

  always @(posedge clk)
    if (valid1 && ready1) words1 <= words1 + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid1(string tag);
    int n = 0;
    while (!valid1 && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(valid1), 32'd1);
  endtask

  initial begin
    logic [7:0] exp;
    int w0;
    clr = 1'b1;
    start1 = 0; ready1 = 0; start3 = 0; ready3 = 0;
    mem1 = 8'h00; mem3 = 8'h00;
    step(); step();
    clr = 1'b0;
    check("rst_rsel", 32'(rsel1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_dout", 32'(dout1), 0);
    check("rst_valid", 32'(valid1), 0);
    check("rst_valid3", 32'(valid3), 0);

    // 1: basic scan, S=1
    mem1 = 8'hA5;
    start1 = 1; step(); start1 = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_rsel%0d", k), 32'(rsel1), 32'(k));
      check($sformatf("t1_busy%0d", k), 32'(busy1), 1);
      check($sformatf("t1_nv%0d", k), 32'(valid1), 0);
      check($sformatf("t1_dstable%0d", k), 32'(dout1), 0);
      step();
    end
    check("t1_valid", 32'(valid1), 1);
    check("t1_dout", 32'(dout1), 32'hA5);
    check("t1_busy_hold", 32'(busy1), 1);
    check("t1_rsel_hold", 32'(rsel1), 0);

    // 2: backpressure
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_valid_held", 32'(valid1), 1);
      check("t2_dout_held", 32'(dout1), 32'hA5);
    end
    ready1 = 1; step(); ready1 = 0;
    check("t2_valid_drop", 32'(valid1), 0);
    check("t2_busy_drop", 32'(busy1), 0);
    check("t2_words", 32'(words1), 1);

    // 3: start while busy and at handshake both ignored
    mem1 = 8'h5A;
    w0 = words1;
    start1 = 1; step(); start1 = 0;
    step(); step();
    start1 = 1; step(); start1 = 0;
    wait_valid1("t3_valid");
    check("t3_dout", 32'(dout1), 32'h5A);
    ready1 = 1; start1 = 1; step(); ready1 = 0; start1 = 0;
    check("t3_valid_drop", 32'(valid1), 0);
    for (int k = 0; k < 12; k++) step();
    check("t3_no_rescan", 32'(busy1), 0);
    check("t3_no_valid", 32'(valid1), 0);
    check("t3_one_word", 32'(words1 - w0), 1);

    // 4: clear mid-scan
    mem1 = 8'hFF;
    start1 = 1; step(); start1 = 0;
    step(); step(); step();
    clr = 1; step(); clr = 0;
    check("t4_busy", 32'(busy1), 0);
    check("t4_rsel", 32'(rsel1), 0);
    check("t4_dout", 32'(dout1), 0);
    check("t4_valid", 32'(valid1), 0);
    for (int k = 0; k < 10; k++) step();
    check("t4_no_partial", 32'(valid1), 0);
    mem1 = 8'h3C;
    start1 = 1; step(); start1 = 0;
    wait_valid1("t4_valid2");
    check("t4_dout2", 32'(dout1), 32'h3C);
    ready1 = 1; step(); ready1 = 0;

    // 5: S=3 dwell
    mem3 = 8'h81;
    start3 = 1; step(); start3 = 0;
    for (int k = 0; k < 8; k++)
      for (int s = 0; s < 3; s++) begin
        check($sformatf("t5_rsel%0d_%0d", k, s), 32'(rsel3), 32'(k));
        check($sformatf("t5_nv%0d_%0d", k, s), 32'(valid3), 0);
        step();
      end
    check("t5_valid", 32'(valid3), 1);
    check("t5_dout", 32'(dout3), 32'h81);
    ready3 = 1; step(); ready3 = 0;
    check("t5_idle", 32'(busy3), 0);

    // 6: back-to-back random rounds
    w0 = words1;
    for (int r = 0; r < 10; r++) begin
      exp = 8'($urandom);
      mem1 = exp;
      start1 = 1; step(); start1 = 0;
      wait_valid1($sformatf("t6_valid%0d", r));
      check($sformatf("t6_dout%0d", r), 32'(dout1), 32'(exp));
      ready1 = 1; step(); ready1 = 0;
    end
    check("t6_words", 32'(words1 - w0), 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
